// File: rtl/hwag_pkg.sv
// Shared types and default widths for the angle-generator ignition blocks.
// Holds the coil_guard channel state encoding.
package hwag_pkg;

    localparam int CG_CNT_WIDTH = 24;
    localparam int CG_OFF_WIDTH = 16;

    typedef enum logic [1:0] {
        CG_IDLE     = 2'd0,
        CG_CHARGE   = 2'd1,
        CG_OFF_HOLD = 2'd2,
        CG_LOCKOUT  = 2'd3
    } cg_state_t;

endpackage

// File: rtl/coil_guard_timer.sv
// Saturating up-counter shared by the charge and off-hold phases of coil_guard.
// Clear has priority over increment; o_next is the saturated count+1.
module coil_guard_timer
    import hwag_pkg::*;
#(
    parameter int CNT_WIDTH = CG_CNT_WIDTH
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 i_clr,
    input  logic                 i_inc,
    output logic [CNT_WIDTH-1:0] o_count,
    output logic [CNT_WIDTH-1:0] o_next
);

    logic [CNT_WIDTH-1:0] r_count;

    assign o_count = r_count;
    assign o_next  = (&r_count) ? r_count : r_count + CNT_WIDTH'(1);

    always_ff @(posedge clk) begin
        if (rst || i_clr) begin
            r_count <= '0;
        end else if (i_inc) begin
            r_count <= o_next;
        end
    end

endmodule

// File: rtl/coil_guard.sv
// Ignition coil dwell guard: charges on a request rising edge, enforces a maximum
// dwell and a minimum off time, and locks the channel when the angle base is lost.
module coil_guard
    import hwag_pkg::*;
#(
    parameter int CNT_WIDTH = CG_CNT_WIDTH,
    parameter int OFF_WIDTH = CG_OFF_WIDTH
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 coil_req,
    input  logic                 hwag_run,
    input  logic [CNT_WIDTH-1:0] cfg_max_dwell,
    input  logic [OFF_WIDTH-1:0] cfg_min_off,
    output logic                 coil_out,
    output logic                 overrun,
    output logic                 skipped,
    output logic                 lockout,
    output logic [CNT_WIDTH-1:0] dwell_last
);

    cg_state_t            r_state;
    logic                 r_req_q;
    logic [CNT_WIDTH-1:0] r_max_shadow;
    logic [CNT_WIDTH-1:0] r_off_shadow;

    logic                 w_rise;
    logic                 w_fall;
    logic                 w_lim_hit;
    logic                 w_off_done;
    logic                 w_tmr_inc;
    logic                 w_tmr_clr;
    logic [CNT_WIDTH-1:0] w_tmr_count;
    logic [CNT_WIDTH-1:0] w_tmr_next;

    assign w_rise     = coil_req & ~r_req_q;
    assign w_fall     = ~coil_req & r_req_q;
    assign w_lim_hit  = (r_max_shadow != '0) && (w_tmr_next == r_max_shadow);
    assign w_off_done = (w_tmr_next >= r_off_shadow);

    // The timer only runs while the current phase continues; any exit clears it,
    // so every phase entry starts counting from zero.
    assign w_tmr_inc = hwag_run &&
                       (((r_state == CG_CHARGE)   && !w_fall && !w_lim_hit) ||
                        ((r_state == CG_OFF_HOLD) && !w_off_done));
    assign w_tmr_clr = ~w_tmr_inc;

    coil_guard_timer #(
        .CNT_WIDTH (CNT_WIDTH)
    ) u_timer (
        .clk     (clk),
        .rst     (rst),
        .i_clr   (w_tmr_clr),
        .i_inc   (w_tmr_inc),
        .o_count (w_tmr_count),
        .o_next  (w_tmr_next)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= CG_IDLE;
            r_req_q      <= 1'b0;
            r_max_shadow <= '0;
            r_off_shadow <= '0;
            coil_out     <= 1'b0;
            overrun      <= 1'b0;
            skipped      <= 1'b0;
            lockout      <= 1'b0;
            dwell_last   <= '0;
        end else begin
            r_req_q <= coil_req;
            overrun <= 1'b0;
            skipped <= 1'b0;
            case (r_state)
                CG_IDLE: begin
                    if (w_rise && hwag_run) begin
                        r_state      <= CG_CHARGE;
                        coil_out     <= 1'b1;
                        r_max_shadow <= cfg_max_dwell;
                    end else if (w_rise) begin
                        skipped <= 1'b1;
                    end
                end
                CG_CHARGE: begin
                    // Loss of the angle base wins over both fall and limit.
                    if (!hwag_run) begin
                        r_state  <= CG_LOCKOUT;
                        coil_out <= 1'b0;
                        lockout  <= 1'b1;
                    end else if (w_fall) begin
                        r_state      <= CG_OFF_HOLD;
                        coil_out     <= 1'b0;
                        dwell_last   <= w_tmr_next;
                        r_off_shadow <= CNT_WIDTH'(cfg_min_off);
                    end else if (w_lim_hit) begin
                        r_state      <= CG_OFF_HOLD;
                        coil_out     <= 1'b0;
                        overrun      <= 1'b1;
                        dwell_last   <= r_max_shadow;
                        r_off_shadow <= CNT_WIDTH'(cfg_min_off);
                    end
                end
                CG_OFF_HOLD: begin
                    skipped <= w_rise;
                    if (!hwag_run) begin
                        r_state <= CG_LOCKOUT;
                        lockout <= 1'b1;
                    end else if (w_off_done) begin
                        r_state <= CG_IDLE;
                    end
                end
                CG_LOCKOUT: begin
                    if (hwag_run && !coil_req) begin
                        r_state <= CG_IDLE;
                        lockout <= 1'b0;
                    end
                end
                default: begin
                    r_state  <= CG_IDLE;
                    coil_out <= 1'b0;
                    lockout  <= 1'b0;
                end
            endcase
        end
    end

endmodule
